// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Brief    : Shared types and default widths for the MIPS32 memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam int c_DEFAULT_AW = 10;
  localparam int c_DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_DAT  = 2'd2,
    REQ_IF   = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mips_arb_pick
// Brief    : Combinational winner selection: loader > data > fetch, with fetch
//            promoted above data while the starve flag is raised.
// Revision : 1.0 - initial release
// ============================================================================
module mips_arb_pick
  import mips_mem_pkg::*;
(
  input  logic       ld_req,
  input  logic       dat_req,
  input  logic       if_req,
  input  logic       starve,
  output logic [1:0] winner
);

  always_comb begin
    winner = REQ_NONE;
    if (ld_req)
      winner = REQ_LD;
    else if (starve && if_req)
      winner = REQ_IF;
    else if (dat_req)
      winner = REQ_DAT;
    else if (if_req)
      winner = REQ_IF;
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arbiter
// Brief    : Single-port memory arbiter for loader, data and fetch requesters.
//            Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = c_DEFAULT_AW,
  parameter int DW         = c_DEFAULT_DW,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          ld_req,
  input  logic          dat_req,
  input  logic          if_req,
  input  logic          ld_we,
  input  logic          dat_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] dat_addr,
  input  logic [AW-1:0] if_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic [DW-1:0] dat_wdata,
  output logic          ld_gnt,
  output logic          dat_gnt,
  output logic          if_gnt,
  output logic          ld_rvalid,
  output logic          dat_rvalid,
  output logic          if_rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] c_LAT_LAST = 3'(MEM_LAT - 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  req_id_e       r_owner;
  req_id_e       w_owner_nxt;
  req_id_e       w_winner;
  logic [1:0]    w_pick;
  logic [2:0]    r_lat_cnt;
  logic [2:0]    w_lat_nxt;
  logic          w_capture;
  logic          w_starve;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  logic          r_ld_gnt;
  logic          r_dat_gnt;
  logic          r_if_gnt;
  logic          r_ld_rvalid;
  logic          r_dat_rvalid;
  logic          r_if_rvalid;
  logic          r_busy;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_rdata;

  mips_arb_pick u_pick (
    .ld_req  (ld_req),
    .dat_req (dat_req),
    .if_req  (if_req),
    .starve  (w_starve),
    .winner  (w_pick)
  );

  assign w_winner = req_id_e'(w_pick);

`ifdef ARB_STARVE_GUARD_EN
  localparam int c_SW = $clog2(STARVE_MAX + 1);

  logic [c_SW-1:0] r_starve_cnt;

  // Counts back-to-back data wins taken while fetch was also asking.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_capture) begin
      if (w_winner == REQ_IF) begin
        r_starve_cnt <= '0;
      end else if (w_winner == REQ_DAT) begin
        if (!if_req)
          r_starve_cnt <= '0;
        else if (!w_starve)
          r_starve_cnt <= r_starve_cnt + c_SW'(1);
      end
    end
  end

  assign w_starve = (r_starve_cnt >= c_SW'(STARVE_MAX));
`else
  assign w_starve = 1'b0 & (STARVE_MAX > 0);
`endif

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = if_addr;
    w_sel_wdata = '0;
    case (w_winner)
      REQ_LD: begin
        w_sel_we    = ld_we;
        w_sel_addr  = ld_addr;
        w_sel_wdata = ld_wdata;
      end
      REQ_DAT: begin
        w_sel_we    = dat_we;
        w_sel_addr  = dat_addr;
        w_sel_wdata = dat_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lat_nxt   = r_lat_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_winner != REQ_NONE) begin
          w_state_nxt = ISSUE;
          w_owner_nxt = w_winner;
          w_capture   = 1'b1;
        end
      end
      ISSUE: begin
        w_lat_nxt   = '0;
        w_state_nxt = r_mem_we ? DONE : WAIT;
      end
      WAIT: begin
        if (r_lat_cnt == c_LAT_LAST)
          w_state_nxt = DONE;
        else
          w_lat_nxt = r_lat_cnt + 3'd1;
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_owner_nxt = REQ_NONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= REQ_NONE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_lat_cnt <= w_lat_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_ld_gnt     <= 1'b0;
      r_dat_gnt    <= 1'b0;
      r_if_gnt     <= 1'b0;
      r_ld_rvalid  <= 1'b0;
      r_dat_rvalid <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
    end else begin
      r_ld_gnt     <= (w_state_nxt == ISSUE) && (w_owner_nxt == REQ_LD);
      r_dat_gnt    <= (w_state_nxt == ISSUE) && (w_owner_nxt == REQ_DAT);
      r_if_gnt     <= (w_state_nxt == ISSUE) && (w_owner_nxt == REQ_IF);
      r_ld_rvalid  <= (w_state_nxt == DONE) && (w_owner_nxt == REQ_LD);
      r_dat_rvalid <= (w_state_nxt == DONE) && (w_owner_nxt == REQ_DAT);
      r_if_rvalid  <= (w_state_nxt == DONE) && (w_owner_nxt == REQ_IF);
      r_busy       <= (w_state_nxt != IDLE);
      r_mem_en     <= (w_state_nxt == ISSUE);
      if (w_capture) begin
        r_mem_we    <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      if ((r_state == WAIT) && (r_lat_cnt == c_LAT_LAST))
        r_rdata <= mem_rdata;
    end
  end

  assign ld_gnt     = r_ld_gnt;
  assign dat_gnt    = r_dat_gnt;
  assign if_gnt     = r_if_gnt;
  assign ld_rvalid  = r_ld_rvalid;
  assign dat_rvalid = r_dat_rvalid;
  assign if_rvalid  = r_if_rvalid;
  assign busy       = r_busy;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign rdata      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mem_arbiter
// Brief    : Self-checking bench: directed table, corner sequences and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int L      = 2;
  localparam int STARVE = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit c_GUARD = 1'b1;
`else
  localparam bit c_GUARD = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        ld_req, dat_req, if_req, ld_we, dat_we;
  logic [9:0]  ld_addr, dat_addr, if_addr;
  logic [31:0] ld_wdata, dat_wdata;
  logic        ld_gnt, dat_gnt, if_gnt, ld_rvalid, dat_rvalid, if_rvalid;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_we;
  logic [9:0]  mem_addr;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(L), .STARVE_MAX(STARVE)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .ld_req(ld_req), .dat_req(dat_req), .if_req(if_req),
    .ld_we(ld_we), .dat_we(dat_we),
    .ld_addr(ld_addr), .dat_addr(dat_addr), .if_addr(if_addr),
    .ld_wdata(ld_wdata), .dat_wdata(dat_wdata),
    .ld_gnt(ld_gnt), .dat_gnt(dat_gnt), .if_gnt(if_gnt),
    .ld_rvalid(ld_rvalid), .dat_rvalid(dat_rvalid), .if_rvalid(if_rvalid),
    .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int a);
    return (a == 5) ? 32'h2800_000A : (32'hC0DE_0000 | 32'(a));
  endfunction

  // Memory macro: read data appears L cycles after the strobe.
  logic [31:0] mem [0:1023];
  logic [31:0] pipe [0:3];
  logic        mem_ready = 1'b0;
  always @(posedge clk1) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[L-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input int who, input logic req, input logic we, input logic [9:0] a, input logic [31:0] d);
    case (who)
      1: begin ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d; end
      2: begin dat_req = req; dat_we = we; dat_addr = a; dat_wdata = d; end
      default: begin if_req = req; if_addr = a; end
    endcase
  endtask

  function automatic logic gnt_of(input int who);
    case (who)
      1: return ld_gnt;
      2: return dat_gnt;
      default: return if_gnt;
    endcase
  endfunction

  function automatic logic rv_of(input int who);
    case (who)
      1: return ld_rvalid;
      2: return dat_rvalid;
      default: return if_rvalid;
    endcase
  endfunction

  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_rd;

  typedef struct {
    int          who;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;
  vec_t tbl [9];

  task automatic do_txn(input vec_t v);
    int c, gc, rc;
    c = 0; gc = -1; rc = -1;
    drive(v.who, 1'b1, v.we, v.addr, v.wd);
    while (c < 20 && rc < 0) begin
      @(posedge clk1); #1;
      c++;
      if (gnt_of(v.who)) begin
        gc = c;
        check("txn_mem_addr", 64'(mem_addr), 64'(v.addr));
        check("txn_mem_en_we", 64'({mem_en, mem_we}), 64'({1'b1, v.we}));
        drive(v.who, 1'b0, 1'b0, 10'h0, 32'h0);
      end
      if (rv_of(v.who)) rc = c;
    end
    check("txn_gnt_lat", 64'(gc), 64'(1));
    check("txn_rvalid_lat", 64'(rc), 64'(v.exp_lat));
    if (v.we) ref_mem[v.addr] = v.wd;
    else last_rd = v.exp_rd;
    check("txn_rdata", 64'(rdata), 64'(last_rd));
    @(posedge clk1); #1;
    check("txn_back_idle", 64'({busy, rv_of(v.who)}), 64'(0));
  endtask

  // Transaction-level reference model used by the randomized run.
  bit          m_active;
  int          m_age, m_len, m_owner, m_starve;
  logic        m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wd, m_rd_pend, m_rdata;

  task automatic model_step();
    int win;
    if (m_active) begin
      m_age++;
      if (m_age == m_len) m_active = 1'b0;
      else if (m_age == m_len - 1 && !m_we) m_rdata = m_rd_pend;
    end else begin
      win = 0;
      if (ld_req) win = 1;
      else if (c_GUARD && m_starve >= STARVE && if_req) win = 3;
      else if (dat_req) win = 2;
      else if (if_req) win = 3;
      if (win != 0) begin
        m_active = 1'b1; m_age = 0; m_owner = win;
        case (win)
          1: begin m_we = ld_we; m_addr = ld_addr; m_wd = ld_wdata; end
          2: begin m_we = dat_we; m_addr = dat_addr; m_wd = dat_wdata; end
          default: begin m_we = 1'b0; m_addr = if_addr; m_wd = 32'h0; end
        endcase
        m_len = m_we ? 2 : L + 2;
        if (m_we) ref_mem[m_addr] = m_wd;
        else m_rd_pend = ref_mem[m_addr];
        if (win == 3) m_starve = 0;
        else if (win == 2) m_starve = if_req ? m_starve + 1 : 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [8];
    int gcyc [1:3];
    int gcnt [1:3];
    int c, n, rv_seen;
    bit          pend [1:3];
    logic        pw [1:3];
    logic [9:0]  pa [1:3];
    logic [31:0] pd [1:3];
    logic        e_en;

    tbl[0] = '{3, 1'b0, 10'd5,   32'h0,         32'h2800_000A, L + 2};
    tbl[1] = '{2, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 32'h0,         2};
    tbl[2] = '{2, 1'b0, 10'h3FF, 32'h0,         32'hDEAD_BEEF, L + 2};
    tbl[3] = '{1, 1'b1, 10'd0,   32'h1234_5678, 32'h0,         2};
    tbl[4] = '{3, 1'b0, 10'd0,   32'h0,         32'h1234_5678, L + 2};
    tbl[5] = '{1, 1'b0, 10'h3FF, 32'h0,         32'hDEAD_BEEF, L + 2};
    tbl[6] = '{2, 1'b1, 10'd1,   32'h0,         32'h0,         2};
    tbl[7] = '{2, 1'b0, 10'd1,   32'h0,         32'h0,         L + 2};
    tbl[8] = '{3, 1'b0, 10'd9,   32'h0,         init_val(9),   L + 2};

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    for (int r = 1; r <= 3; r++) drive(r, 1'b0, 1'b0, 10'h0, 32'h0);
    last_rd = 32'h0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    check("rst_ctrl", 64'({ld_gnt, dat_gnt, if_gnt, ld_rvalid, dat_rvalid, if_rvalid, busy, mem_en, mem_we}), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // Directed single transactions
    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    // Three-way contention, each requester drops after its grant
    for (int w = 1; w <= 3; w++) begin gcyc[w] = -1; gcnt[w] = 0; end
    drive(1, 1'b1, 1'b1, 10'd7, 32'hA1B2_C3D4);
    drive(2, 1'b1, 1'b0, 10'd5, 32'h0);
    drive(3, 1'b1, 1'b0, 10'd9, 32'h0);
    for (int cc = 1; cc <= 30; cc++) begin
      @(posedge clk1); #1;
      for (int w = 1; w <= 3; w++) begin
        if (gnt_of(w)) begin
          gcnt[w]++;
          if (gcyc[w] < 0) gcyc[w] = cc;
          drive(w, 1'b0, 1'b0, 10'h0, 32'h0);
        end
      end
    end
    ref_mem[7] = 32'hA1B2_C3D4;
    last_rd = init_val(9);
    check("cont_ld_cycle", 64'(gcyc[1]), 64'(1));
    check("cont_dat_cycle", 64'(gcyc[2]), 64'(4));
    check("cont_if_cycle", 64'(gcyc[3]), 64'(L + 7));
    check("cont_gnt_widths", 64'({gcnt[1][3:0], gcnt[2][3:0], gcnt[3][3:0]}), 64'(12'h111));
    check("cont_rdata", 64'(rdata), 64'(last_rd));

    // Reset during WAIT of a fetch read
    drive(3, 1'b1, 1'b0, 10'd5, 32'h0);
    @(posedge clk1); #1;
    check("rstw_gnt", 64'(if_gnt), 64'(1));
    drive(3, 1'b0, 1'b0, 10'h0, 32'h0);
    @(posedge clk1); #1;
    rst_n = 1'b0;
    @(posedge clk1); #1;
    check("rstw_ctrl", 64'({ld_gnt, dat_gnt, if_gnt, ld_rvalid, dat_rvalid, if_rvalid, busy, mem_en, mem_we}), 64'(0));
    check("rstw_data", 64'({mem_addr, rdata}), 64'(0));
    check("rstw_wdata", 64'(mem_wdata), 64'(0));
    rst_n = 1'b1;
    last_rd = 32'h0;
    rv_seen = 0;
    repeat (8) begin
      @(posedge clk1); #1;
      if (if_rvalid) rv_seen++;
    end
    check("rstw_no_rvalid", 64'(rv_seen), 64'(0));
    do_txn(tbl[0]);

    // Starvation: data and fetch held high
    for (int i = 0; i < 8; i++) seq[i] = 0;
    drive(2, 1'b1, 1'b0, 10'd3, 32'h0);
    drive(3, 1'b1, 1'b0, 10'd4, 32'h0);
    n = 0; c = 0;
    while (n < 8 && c < 200) begin
      @(posedge clk1); #1;
      c++;
      if (dat_gnt) begin seq[n] = 2; n++; end
      else if (if_gnt) begin seq[n] = 3; n++; end
    end
    drive(2, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 10'h0, 32'h0);
    repeat (L + 4) @(posedge clk1);
    for (int i = 0; i < 8; i++)
      check($sformatf("starve_grant%0d", i), 64'(seq[i]), 64'((c_GUARD && (i % 4 == 3)) ? 3 : 2));

    // Randomized run against the reference model
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    m_active = 1'b0; m_age = 0; m_len = 0; m_owner = 0; m_starve = 0;
    m_we = 1'b0; m_addr = 10'h0; m_wd = 32'h0; m_rd_pend = 32'h0; m_rdata = 32'h0;
    for (int r = 1; r <= 3; r++) begin pend[r] = 1'b0; pw[r] = 1'b0; pa[r] = 10'h0; pd[r] = 32'h0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk1);
      model_step();
      #1;
      e_en = m_active && (m_age == 0);
      check("rnd_ctrl",
            64'({ld_gnt, dat_gnt, if_gnt, ld_rvalid, dat_rvalid, if_rvalid, busy, mem_en}),
            64'({e_en && m_owner == 1, e_en && m_owner == 2, e_en && m_owner == 3,
                 m_active && m_age == m_len - 1 && m_owner == 1,
                 m_active && m_age == m_len - 1 && m_owner == 2,
                 m_active && m_age == m_len - 1 && m_owner == 3,
                 m_active, e_en}));
      check("rnd_rdata", 64'(rdata), 64'(m_rdata));
      if (e_en)
        check("rnd_mem_req", 64'({mem_we, mem_addr, (m_we ? mem_wdata : 32'h0)}),
              64'({m_we, m_addr, (m_we ? m_wd : 32'h0)}));
      for (int r = 1; r <= 3; r++) begin
        if (pend[r] && gnt_of(r)) pend[r] = 1'b0;
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pa[r] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
          pw[r] = (r != 3) && ($urandom_range(0, 1) == 1);
          pd[r] = $urandom;
        end
        drive(r, pend[r], pw[r], pa[r], pd[r]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
